// File: rtl/cpu_control_fsm.sv
// ---------------------------------------------------------------------------
// cpu_control_fsm
//   Multi-cycle fetch/decode/execute sequencer feeding reg_file_alu.
//   Holds the program counter, latches the 16-bit instruction returned by a
//   combinational instruction memory, decodes it into the register-file/ALU
//   control bundle and resolves BZ using the ALU Zero output.
//   Every instruction takes three cycles: FETCH -> DECODE -> EXEC.
//
// Ports
//   CLK          in   system clock, rising edge
//   reset        in   synchronous, active-high
//   start        in   one-cycle pulse, leaves IDLE
//   instr        in   instruction memory data at address pc (same cycle)
//   pc           out  program counter / instruction memory address
//   RA1/RA2/WA   out  register file read/read/write addresses
//   immediate    out  8-bit immediate operand
//   ALUControl   out  00 add, 01 sub, 10 and, 11 or
//   ALUSrc       out  0 = RD2, 1 = immediate
//   write_enable out  register file write strobe (one EXEC cycle, ALU ops)
//   Zero         in   ALU result == 0
//   halted       out  high in HALT
//
// INSTR_W must be 16; the field layout below is hard-wired to it.
// ---------------------------------------------------------------------------
module cpu_control_fsm #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               start,
  input  logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc,
  output logic [3:0]         RA1,
  output logic [3:0]         RA2,
  output logic [3:0]         WA,
  output logic [7:0]         immediate,
  output logic [1:0]         ALUControl,
  output logic               ALUSrc,
  output logic               write_enable,
  input  logic               Zero,
  output logic               halted
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_SUBI = 4'h6;
  localparam logic [3:0] OP_BZ   = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic                 z_q, z_d;

  // Instruction fields
  logic [3:0] op, rd, rs1, rs2;
  logic [7:0] imm;

  assign op  = ir_q[15:12];
  assign rd  = ir_q[11:8];
  assign rs1 = ir_q[7:4];
  assign rs2 = ir_q[3:0];
  assign imm = ir_q[7:0];

  logic is_alu_rr, is_alu_imm, is_alu, is_bz, is_jmp, is_halt, taken;
  logic [PC_W-1:0] br_tgt;

  assign is_alu_rr  = (op == OP_ADD) || (op == OP_SUB) ||
                      (op == OP_AND) || (op == OP_OR);
  assign is_alu_imm = (op == OP_ADDI) || (op == OP_SUBI);
  assign is_alu     = is_alu_rr || is_alu_imm;
  assign is_bz      = (op == OP_BZ);
  assign is_jmp     = (op == OP_JMP);
  assign is_halt    = (op == OP_HALT);
  // BZ tests the flag left by the most recent ALU instruction, not the
  // live Zero input (nothing meaningful is on the ALU during a branch).
  assign taken      = is_jmp || (is_bz && z_q);
  // Zero-extend or truncate the 8-bit target to the PC width.
  assign br_tgt     = PC_W'(imm);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // Next-state logic; start only matters in IDLE
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = is_halt ? S_HALT : S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers: pc, IR, Z flag
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (reset) begin
      pc_q <= '0;
      ir_q <= '0;
      z_q  <= 1'b0;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
      z_q  <= z_d;
    end
  end

  // IR loads in FETCH; pc and Z only change on the closing edge of EXEC,
  // so pc stays put from FETCH through EXEC.
  always_comb begin
    pc_d = pc_q;
    ir_d = ir_q;
    z_d  = z_q;
    if (state_q == S_FETCH) ir_d = instr;
    if (state_q == S_EXEC) begin
      if (is_alu) z_d = Zero;
      if (taken)         pc_d = br_tgt;
      else if (!is_halt) pc_d = pc_q + PC_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Output logic: decode straight off IR so the bundle is stable from
  // DECODE through EXEC. Non-ALU opcodes drive the bundle to zero.
  // -------------------------------------------------------------------------
  always_comb begin
    RA1        = 4'h0;
    RA2        = 4'h0;
    WA         = 4'h0;
    immediate  = 8'h00;
    ALUControl = 2'b00;
    ALUSrc     = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        WA  = rd;
        RA1 = rs1;
        RA2 = rs2;
        case (op)
          OP_SUB:  ALUControl = 2'b01;
          OP_AND:  ALUControl = 2'b10;
          OP_OR:   ALUControl = 2'b11;
          default: ALUControl = 2'b00;
        endcase
      end
      OP_ADDI, OP_SUBI: begin
        WA         = rd;
        RA1        = rd;
        immediate  = imm;
        ALUSrc     = 1'b1;
        ALUControl = (op == OP_SUBI) ? 2'b01 : 2'b00;
      end
      default: ;
    endcase

    // Reset in EXEC must suppress the write on that same edge.
    write_enable = (state_q == S_EXEC) && is_alu && !reset;
    halted       = (state_q == S_HALT);
    pc           = pc_q;
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_cpu_control_fsm
//   Directed bench for cpu_control_fsm. The environment provides a
//   combinational instruction memory and a small 16x8 register file + ALU
//   standing in for reg_file_alu. Each scenario task drives stimulus and
//   checks hand-computed expectations inline.
// ---------------------------------------------------------------------------
module tb_cpu_control_fsm;

  logic        CLK;
  logic        reset;
  logic        start;
  logic [15:0] instr;
  logic [7:0]  pc;
  logic [3:0]  RA1, RA2, WA;
  logic [7:0]  immediate;
  logic [1:0]  ALUControl;
  logic        ALUSrc;
  logic        write_enable;
  logic        Zero;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_control_fsm #(.PC_W(8), .INSTR_W(16)) dut (
    .CLK          (CLK),
    .reset        (reset),
    .start        (start),
    .instr        (instr),
    .pc           (pc),
    .RA1          (RA1),
    .RA2          (RA2),
    .WA           (WA),
    .immediate    (immediate),
    .ALUControl   (ALUControl),
    .ALUSrc       (ALUSrc),
    .write_enable (write_enable),
    .Zero         (Zero),
    .halted       (halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Instruction memory
  logic [15:0] imem [0:255];
  assign instr = imem[pc];

  // Register file + ALU model
  logic [7:0] rf [0:15];
  logic [7:0] opb, alu_y;
  logic       rf_clr;

  always_comb begin
    opb = ALUSrc ? immediate : rf[RA2];
    case (ALUControl)
      2'b00:   alu_y = rf[RA1] + opb;
      2'b01:   alu_y = rf[RA1] - opb;
      2'b10:   alu_y = rf[RA1] & opb;
      default: alu_y = rf[RA1] | opb;
    endcase
    Zero = (alu_y == 8'h00);
  end

  always @(posedge CLK) begin
    if (rf_clr) begin
      for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
    end else if (write_enable) begin
      rf[WA] <= alu_y;
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Reset DUT, clear register file and instruction memory.
  task automatic do_reset;
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    reset  = 1'b1;
    rf_clr = 1'b1;
    start  = 1'b0;
    ticks(2);
    reset  = 1'b0;
    rf_clr = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset;
    do_reset();
    reset = 1'b1;
    tick();
    n_checks++;
    if (pc !== 8'h00) begin
      n_fail++; $display("FAIL reset_pc: got %0h expected 0", pc);
    end
    n_checks++;
    if ({write_enable, halted} !== 2'b00) begin
      n_fail++; $display("FAIL reset_we_halted: got %b expected 00", {write_enable, halted});
    end
    n_checks++;
    if ({RA1, RA2, WA, immediate, ALUControl, ALUSrc} !== 23'h0) begin
      n_fail++; $display("FAIL reset_decode: got %0h expected 0",
                         {RA1, RA2, WA, immediate, ALUControl, ALUSrc});
    end
    // Without start the FSM idles: pc does not move, nothing is written.
    reset = 1'b0;
    imem[0] = 16'h5105;
    ticks(5);
    n_checks++;
    if ({pc, write_enable} !== 9'h000) begin
      n_fail++; $display("FAIL idle_hold: got pc=%0h we=%b expected pc=0 we=0", pc, write_enable);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_program;
    logic [3:0] exp_wa  [3];
    logic       exp_src [3];
    exp_wa  = '{4'd1, 4'd2, 4'd3};
    exp_src = '{1'b1, 1'b1, 1'b0};
    do_reset();
    imem[0] = 16'h5105;  // ADDI r1,5
    imem[1] = 16'h5207;  // ADDI r2,7
    imem[2] = 16'h1312;  // ADD  r3,r1,r2
    imem[3] = 16'hF000;  // HALT
    tick();              // cycle 1
    pulse_start();       // start sampled at cycle 2 -> FETCH
    n_checks++;
    if (pc !== 8'h00) begin
      n_fail++; $display("FAIL prog_fetch_pc: got %0h expected 0", pc);
    end
    for (int i = 0; i < 4; i++) begin
      tick();            // DECODE
      n_checks++;
      if (write_enable !== 1'b0) begin
        n_fail++; $display("FAIL prog_decode_we[%0d]: got %b expected 0", i, write_enable);
      end
      tick();            // EXEC
      if (i < 3) begin
        n_checks++;
        if ({write_enable, WA, ALUSrc} !== {1'b1, exp_wa[i], exp_src[i]}) begin
          n_fail++; $display("FAIL prog_exec[%0d]: got we=%b wa=%0d src=%b expected we=1 wa=%0d src=%b",
                             i, write_enable, WA, ALUSrc, exp_wa[i], exp_src[i]);
        end
      end else begin
        n_checks++;
        if (write_enable !== 1'b0) begin
          n_fail++; $display("FAIL prog_halt_we: got %b expected 0", write_enable);
        end
      end
      tick();            // closing edge
    end
    n_checks++;
    if ({halted, pc} !== {1'b1, 8'h03}) begin
      n_fail++; $display("FAIL prog_halted: got halted=%b pc=%0h expected halted=1 pc=3", halted, pc);
    end
    n_checks++;
    if (rf[3] !== 8'd12) begin
      n_fail++; $display("FAIL prog_r3: got %0d expected 12", rf[3]);
    end
    ticks(4);
    n_checks++;
    if ({halted, pc, write_enable} !== {1'b1, 8'h03, 1'b0}) begin
      n_fail++; $display("FAIL prog_halt_hold: got halted=%b pc=%0h we=%b expected 1/3/0",
                         halted, pc, write_enable);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic run_branch(input logic [7:0] v, input logic [7:0] exp_pc);
    do_reset();
    imem[0]     = {8'h51, v};  // ADDI r1,v
    imem[1]     = 16'h6105;    // SUBI r1,5
    imem[2]     = 16'h8020;    // BZ 0x20
    imem[3]     = 16'hF000;
    imem[8'h20] = 16'hF000;
    tick();
    pulse_start();
    ticks(9);                  // three instructions retired
    n_checks++;
    if (pc !== exp_pc) begin
      n_fail++; $display("FAIL branch_pc(v=%0d): got %0h expected %0h", v, pc, exp_pc);
    end
    n_checks++;
    if (rf[1] !== v - 8'd5) begin
      n_fail++; $display("FAIL branch_r1(v=%0d): got %0d expected %0d", v, rf[1], v - 8'd5);
    end
    ticks(3);
    n_checks++;
    if ({halted, pc} !== {1'b1, exp_pc}) begin
      n_fail++; $display("FAIL branch_halt(v=%0d): got halted=%b pc=%0h expected 1/%0h",
                         v, halted, pc, exp_pc);
    end
  endtask

  task automatic test_branch;
    run_branch(8'd5, 8'h20);   // r1-5 == 0 -> taken
    run_branch(8'd6, 8'h03);   // r1-5 != 0 -> fall through
  endtask

  // -------------------------------------------------------------------------
  task automatic test_jmp_wrap;
    logic we_seen;
    do_reset();
    imem[0]     = 16'h5100;    // ADDI r1,0 -> Z=1
    imem[1]     = 16'h90FF;    // JMP 0xFF
    imem[8'hFF] = 16'h0000;    // NOP
    tick();
    pulse_start();
    ticks(3);
    we_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      we_seen = we_seen | write_enable;
    end
    n_checks++;
    if ({we_seen, pc} !== {1'b0, 8'hFF}) begin
      n_fail++; $display("FAIL jmp: got we_seen=%b pc=%0h expected 0/ff", we_seen, pc);
    end
    // Re-purpose address 0 so the wrap lands on a BZ that exposes Z.
    imem[0]     = 16'h8040;
    imem[8'h40] = 16'hF000;
    we_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      we_seen = we_seen | write_enable;
    end
    n_checks++;
    if ({we_seen, pc} !== {1'b0, 8'h00}) begin
      n_fail++; $display("FAIL nop_wrap: got we_seen=%b pc=%0h expected 0/0", we_seen, pc);
    end
    ticks(3);
    n_checks++;
    if (pc !== 8'h40) begin
      n_fail++; $display("FAIL z_preserved: got pc=%0h expected 40", pc);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_exec;
    do_reset();
    imem[0] = 16'h5103;        // ADDI r1,3
    imem[1] = 16'h5204;        // ADDI r2,4
    imem[2] = 16'h1412;        // ADD  r4,r1,r2
    imem[3] = 16'hF000;
    tick();
    pulse_start();
    ticks(8);                  // now in EXEC of ADD
    n_checks++;
    if ({write_enable, WA} !== {1'b1, 4'd4}) begin
      n_fail++; $display("FAIL rst_exec_pre: got we=%b wa=%0d expected 1/4", write_enable, WA);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (write_enable !== 1'b0) begin
      n_fail++; $display("FAIL rst_exec_we: got %b expected 0", write_enable);
    end
    tick();
    reset = 1'b0;
    n_checks++;
    if (rf[4] !== 8'h00) begin
      n_fail++; $display("FAIL rst_exec_r4: got %0d expected 0", rf[4]);
    end
    n_checks++;
    if ({pc, halted, write_enable, RA1, RA2, WA, immediate, ALUControl, ALUSrc} !== 33'h0) begin
      n_fail++; $display("FAIL rst_exec_outs: got pc=%0h halted=%b we=%b wa=%0d expected all 0",
                         pc, halted, write_enable, WA);
    end
    ticks(4);                  // IDLE: a running core would be at pc=1 by now
    n_checks++;
    if ({pc, write_enable} !== 9'h000) begin
      n_fail++; $display("FAIL rst_exec_idle: got pc=%0h we=%b expected 0/0", pc, write_enable);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_start_ignored;
    do_reset();
    imem[0] = 16'hC123;        // undefined opcode -> NOP
    imem[1] = 16'hF000;
    tick();
    pulse_start();
    start = 1'b1;              // held high through the rest of the run
    tick();                    // DECODE
    n_checks++;
    if (pc !== 8'h00) begin
      n_fail++; $display("FAIL start_decode_pc: got %0h expected 0", pc);
    end
    tick();                    // EXEC
    n_checks++;
    if ({pc, write_enable, RA1, RA2, WA, immediate, ALUControl, ALUSrc} !== 32'h0) begin
      n_fail++; $display("FAIL undef_decode: got pc=%0h we=%b ra1=%0h wa=%0h imm=%0h expected all 0",
                         pc, write_enable, RA1, WA, immediate);
    end
    tick();                    // FETCH of next
    n_checks++;
    if (pc !== 8'h01) begin
      n_fail++; $display("FAIL undef_pc: got %0h expected 1", pc);
    end
    ticks(3);
    n_checks++;
    if ({halted, pc} !== {1'b1, 8'h01}) begin
      n_fail++; $display("FAIL start_halt: got halted=%b pc=%0h expected 1/1", halted, pc);
    end
    ticks(3);
    start = 1'b0;
    n_checks++;
    if ({halted, pc} !== {1'b1, 8'h01}) begin
      n_fail++; $display("FAIL start_in_halt: got halted=%b pc=%0h expected 1/1", halted, pc);
    end
  endtask

  // -------------------------------------------------------------------------
  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    rf_clr = 1'b1;
    test_reset();
    test_program();
    test_branch();
    test_jmp_wrap();
    test_reset_exec();
    test_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
